// File: rtl/round_controller.sv
// Game sequencer for the mastermind datapath: arbitrates player enters, strobes code/guess
// letter writes, starts the comparator and tracks lives, scores, rounds and role swaps.
module round_controller #(
    parameter int NUM_SLOTS   = 4,
    parameter int LIVES       = 3,
    parameter int WIN_SCORE   = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enterA,
    input  logic       enterB,
    input  logic [2:0] SW,
    input  logic       cmp_valid,
    input  logic       cmp_exact,
    output logic       secret_we,
    output logic       guess_we,
    output logic [1:0] slot_idx,
    output logic [2:0] wr_data,
    output logic       cmp_start,
    output logic       maker_is_a,
    output logic [1:0] lives,
    output logic [1:0] round_count,
    output logic [1:0] scoreA,
    output logic [1:0] scoreB,
    output logic       round_done,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        MAKER,
        BREAKER,
        COMPARE,
        HOLD,
        ROUND_END,
        FINISH
    } state_t;

    localparam logic [1:0] LAST_SLOT  = 2'(NUM_SLOTS - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [1:0] WIN        = 2'(WIN_SCORE);
    localparam int         HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state, state_n;
    logic [1:0]        slot_n;
    logic              secret_we_n, guess_we_n;
    logic [2:0]        wr_data_n;
    logic              maker_is_a_n;
    logic [1:0]        lives_n, round_count_n, scoreA_n, scoreB_n;
    logic              solved, solved_n;
    logic              cmp_issued, cmp_issued_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              maker_enter, breaker_enter, last_pending;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign cmp_start  = (state == COMPARE) && !cmp_issued;
    assign round_done = (state == ROUND_END);
    assign game_over  = (state == FINISH);

    assign maker_enter   = maker_is_a ? enterA : enterB;
    assign breaker_enter = maker_is_a ? enterB : enterA;
    // Once the final slot's strobe is out, further enters would overrun the code.
    assign last_pending  = (secret_we || guess_we) && (slot_idx == LAST_SLOT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            slot_idx    <= 2'd0;
            secret_we   <= 1'b0;
            guess_we    <= 1'b0;
            wr_data     <= 3'd0;
            maker_is_a  <= 1'b1;
            lives       <= LIVES_INIT;
            round_count <= 2'd0;
            scoreA      <= 2'd0;
            scoreB      <= 2'd0;
            solved      <= 1'b0;
            cmp_issued  <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_n;
            slot_idx    <= slot_n;
            secret_we   <= secret_we_n;
            guess_we    <= guess_we_n;
            wr_data     <= wr_data_n;
            maker_is_a  <= maker_is_a_n;
            lives       <= lives_n;
            round_count <= round_count_n;
            scoreA      <= scoreA_n;
            scoreB      <= scoreB_n;
            solved      <= solved_n;
            cmp_issued  <= cmp_issued_n;
            hold_cnt    <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        slot_n        = slot_idx;
        secret_we_n   = 1'b0;
        guess_we_n    = 1'b0;
        wr_data_n     = wr_data;
        maker_is_a_n  = maker_is_a;
        lives_n       = lives;
        round_count_n = round_count;
        scoreA_n      = scoreA;
        scoreB_n      = scoreB;
        solved_n      = solved;
        cmp_issued_n  = cmp_issued;
        hold_cnt_n    = hold_cnt;

        case (state)
            IDLE: begin
                if (enterA || enterB) begin
                    maker_is_a_n = enterA;
                    slot_n       = 2'd0;
                    state_n      = MAKER;
                end
            end

            MAKER: begin
                if (maker_enter && !last_pending) begin
                    secret_we_n = 1'b1;
                    wr_data_n   = SW;
                end
                if (secret_we) begin
                    if (slot_idx == LAST_SLOT) begin
                        slot_n  = 2'd0;
                        lives_n = LIVES_INIT;
                        state_n = BREAKER;
                    end else begin
                        slot_n = slot_idx + 2'd1;
                    end
                end
            end

            BREAKER: begin
                if (breaker_enter && !last_pending) begin
                    guess_we_n = 1'b1;
                    wr_data_n  = SW;
                end
                if (guess_we) begin
                    if (slot_idx == LAST_SLOT) begin
                        slot_n       = 2'd0;
                        cmp_issued_n = 1'b0;
                        state_n      = COMPARE;
                    end else begin
                        slot_n = slot_idx + 2'd1;
                    end
                end
            end

            COMPARE: begin
                cmp_issued_n = 1'b1;
                if (cmp_valid) begin
                    if (cmp_exact) begin
                        solved_n = 1'b1;
                        if (maker_is_a) scoreB_n = sat_inc(scoreB);
                        else            scoreA_n = sat_inc(scoreA);
                    end else if (lives != 2'd0) begin
                        lives_n = lives - 2'd1;
                    end
                    hold_cnt_n = '0;
                    state_n    = HOLD;
                end
            end

            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (solved || lives == 2'd0) begin
                        state_n = ROUND_END;
                    end else begin
                        slot_n  = 2'd0;
                        state_n = BREAKER;
                    end
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end

            ROUND_END: begin
                round_count_n = sat_inc(round_count);
                solved_n      = 1'b0;
                if (lives == 2'd0) begin
                    if (maker_is_a) scoreA_n = sat_inc(scoreA);
                    else            scoreB_n = sat_inc(scoreB);
                end
                // Decide on the updated scores so a maker's winning point ends the game now.
                if (scoreA_n == WIN || scoreB_n == WIN) begin
                    state_n = FINISH;
                end else begin
                    maker_is_a_n = !maker_is_a;
                    slot_n       = 2'd0;
                    state_n      = MAKER;
                end
            end

            FINISH: begin
                state_n = FINISH;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
